// File: rtl/scfifo_pkg.sv
// Shared constants and helpers for the single-clock normal-mode FIFO read adapters.
package scfifo_pkg;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 3;

  // Credits range over 0..skid_depth inclusive.
  function automatic int unsigned credit_width(input int unsigned skid_depth);
    return $clog2(skid_depth + 1);
  endfunction

endpackage

// File: rtl/scfifo_rd_skid_ring.sv
// Register ring holding returned FIFO words that could not go straight to the output register.
module scfifo_rd_skid_ring #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         aclr,
  input  logic                         sclr,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CNTW-1:0]  count_q, count_d;

  // Depth need not be a power of two, so pointers wrap explicitly.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNTW'(push) - CNTW'(pop);
    if (pop)  head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
    if (push) tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
    if (sclr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !sclr) mem_q[tail_q] <= push_data;
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/scfifo_normal_rd_stream.sv
// Normal-mode FIFO read side: credit-gated rdreq, latency tracking and a skid buffer
// feeding a registered valid/ready stream.
module scfifo_normal_rd_stream
  import scfifo_pkg::*;
#(
  parameter int unsigned WIDTH        = 20,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned SKID_DEPTH   = READ_LATENCY + 2
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             sclr,
  input  logic [WIDTH-1:0] fifo_q,
  input  logic             fifo_empty,
  output logic             fifo_rdreq,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy
);

  localparam int unsigned CW         = credit_width(SKID_DEPTH);
  localparam int unsigned RING_DEPTH = SKID_DEPTH - 1;
  localparam int unsigned RCW        = $clog2(RING_DEPTH + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(SKID_DEPTH);

  if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
    $error("scfifo_normal_rd_stream: READ_LATENCY %0d outside 1..3", READ_LATENCY);
  end
  if (SKID_DEPTH < READ_LATENCY + 2) begin : g_bad_depth
    $error("scfifo_normal_rd_stream: SKID_DEPTH %0d below READ_LATENCY+2", SKID_DEPTH);
  end

  logic [CW-1:0]           credits_q, credits_d;
  logic [READ_LATENCY-1:0] ret_vld_q, ret_vld_d;
  logic [WIDTH-1:0]        dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;

  logic             rdreq, pop, ret;
  logic             ring_push, ring_pop, ring_empty;
  logic [WIDTH-1:0] ring_head;
  logic [RCW-1:0]   ring_count;

  // Issue depends only on registered credits, never on dout_ready.
  assign rdreq      = ~fifo_empty & (credits_q < CREDIT_MAX);
  assign pop        = dout_valid_q & dout_ready;
  assign ret        = ret_vld_q[READ_LATENCY-1];
  assign ring_empty = (ring_count == '0);

  // Ring is only ever non-empty while the output register is full, so the
  // ring head always refills the output before a newer return can.
  always_comb begin
    credits_d    = credits_q + CW'(rdreq) - CW'(pop);
    ret_vld_d    = '0;
    ret_vld_d[0] = rdreq;
    for (int i = 1; i < READ_LATENCY; i++) ret_vld_d[i] = ret_vld_q[i-1];

    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    ring_push    = 1'b0;
    ring_pop     = 1'b0;
    if (pop && !ring_empty) begin
      dout_d    = ring_head;
      ring_pop  = 1'b1;
      ring_push = ret;
    end else if (ret && (!dout_valid_q || pop)) begin
      dout_d       = fifo_q;
      dout_valid_d = 1'b1;
    end else begin
      if (pop) dout_valid_d = 1'b0;
      ring_push = ret;
    end

    if (sclr) begin
      credits_d    = '0;
      ret_vld_d    = '0;
      dout_d       = '0;
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      credits_q    <= '0;
      ret_vld_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      credits_q    <= credits_d;
      ret_vld_q    <= ret_vld_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  scfifo_rd_skid_ring #(
    .WIDTH (WIDTH),
    .DEPTH (RING_DEPTH)
  ) u_ring (
    .clock     (clock),
    .aclr      (aclr),
    .sclr      (sclr),
    .push      (ring_push),
    .push_data (fifo_q),
    .pop       (ring_pop),
    .head_data (ring_head),
    .count     (ring_count)
  );

  assign fifo_rdreq = rdreq;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (credits_q != '0);

endmodule

// File: tb/tb_scfifo_normal_rd_stream.sv
// Bench for scfifo_normal_rd_stream: behavioural normal-mode FIFOs feed two instances
// (latency 1 / depth 3 and latency 3 / depth 5); a scoreboard follows the first.
module tb_scfifo_normal_rd_stream;

  logic clock = 1'b0;
  logic aclr  = 1'b1;
  logic sclr  = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instance 1 signals and its FIFO model
  logic [19:0] fifo_q1;
  logic        fifo_empty1, fifo_rdreq1, dout_valid1, busy1;
  logic [19:0] dout1;
  logic        dout_ready = 1'b0;
  logic        hold1 = 1'b1;
  logic        wr_en1 = 1'b0;
  logic [19:0] wr_data1 = '0;
  logic [19:0] mem1 [0:2047];
  int          wr1, rd1;

  // Instance 2 signals and its FIFO model
  logic [19:0] fifo_q2;
  logic        fifo_empty2, fifo_rdreq2, dout_valid2, busy2;
  logic [19:0] dout2;
  logic        dout_ready2 = 1'b0;
  logic        sclr2 = 1'b0;
  logic        hold2 = 1'b1;
  logic        wr_en2 = 1'b0;
  logic [19:0] wr_data2 = '0;
  logic [19:0] mem2 [0:63];
  logic [19:0] pipe2 [0:2];
  int          wr2, rd2;

  scfifo_normal_rd_stream #(.WIDTH(20), .READ_LATENCY(1), .SKID_DEPTH(3)) dut1 (
    .clock(clock), .aclr(aclr), .sclr(sclr), .fifo_q(fifo_q1), .fifo_empty(fifo_empty1),
    .fifo_rdreq(fifo_rdreq1), .dout(dout1), .dout_valid(dout_valid1),
    .dout_ready(dout_ready), .busy(busy1));

  scfifo_normal_rd_stream #(.WIDTH(20), .READ_LATENCY(3), .SKID_DEPTH(5)) dut2 (
    .clock(clock), .aclr(aclr), .sclr(sclr2), .fifo_q(fifo_q2), .fifo_empty(fifo_empty2),
    .fifo_rdreq(fifo_rdreq2), .dout(dout2), .dout_valid(dout_valid2),
    .dout_ready(dout_ready2), .busy(busy2));

  // Normal-mode FIFO with one-cycle read latency; the sclr leaves stale data on q.
  assign fifo_empty1 = hold1 || (wr1 == rd1);
  always @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wr1 <= 0;
      rd1 <= 0;
    end else if (sclr) begin
      rd1 <= wr1;
    end else begin
      if (wr_en1) begin
        mem1[11'(wr1)] <= wr_data1;
        wr1 <= wr1 + 1;
      end
      if (fifo_rdreq1) begin
        fifo_q1 <= mem1[11'(rd1)];
        rd1 <= rd1 + 1;
      end
    end
  end

  // Normal-mode FIFO with three-cycle read latency.
  assign fifo_empty2 = hold2 || (wr2 == rd2);
  assign fifo_q2     = pipe2[2];
  always @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wr2 <= 0;
      rd2 <= 0;
    end else begin
      if (wr_en2) begin
        mem2[6'(wr2)] <= wr_data2;
        wr2 <= wr2 + 1;
      end
      if (fifo_rdreq2) begin
        pipe2[0] <= mem2[6'(rd2)];
        rd2 <= rd2 + 1;
      end
      pipe2[1] <= pipe2[0];
      pipe2[2] <= pipe2[1];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard and protocol monitor for instance 1, sampled mid-cycle.
  logic [19:0] exp_q [$];
  int          credits_m = 0;
  logic        prev_stall = 1'b0;
  logic [19:0] prev_dout = '0;
  logic [19:0] exp_word;
  always @(negedge clock) begin
    if (aclr) begin
      credits_m  = 0;
      prev_stall = 1'b0;
      exp_q.delete();
    end else begin
      checkOutput("busy vs credits", 32'(busy1), 32'(credits_m != 0));
      if (fifo_rdreq1) checkOutput("rdreq while empty", 32'(fifo_empty1), 32'd0);
      if (prev_stall) begin
        checkOutput("stall valid hold", 32'(dout_valid1), 32'd1);
        checkOutput("stall dout hold", 32'(dout1), 32'(prev_dout));
      end
      if (dout_valid1 && dout_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected beat", 32'(dout1), 32'hFFFFFFFF);
        end else begin
          exp_word = exp_q.pop_front();
          checkOutput("scoreboard beat", 32'(dout1), 32'(exp_word));
        end
      end
      credits_m = credits_m + int'(fifo_rdreq1) - int'(dout_valid1 && dout_ready);
      checkOutput("credits bound", 32'(credits_m <= 3), 32'd1);
      prev_stall = dout_valid1 && !dout_ready;
      prev_dout  = dout1;
      if (sclr) begin
        credits_m  = 0;
        prev_stall = 1'b0;
        exp_q.delete();
      end
    end
  end

  typedef struct {
    logic        ready;
    logic        rdreq;
    logic        valid;
    logic [19:0] dout;
    logic        busy;
  } vec_t;
  vec_t vec [26];

  function automatic vec_t mkVec(input logic r, input logic q, input logic v,
                                 input logic [19:0] d, input logic b);
    vec_t t;
    t.ready = r; t.rdreq = q; t.valid = v; t.dout = d; t.busy = b;
    return t;
  endfunction

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic writeWord(input logic [19:0] w);
    wr_en1 = 1'b1;
    wr_data1 = w;
    exp_q.push_back(w);
    @(posedge clock); #1;
    wr_en1 = 1'b0;
  endtask

  task automatic doReset();
    aclr = 1'b1;
    @(posedge clock); #1;
    aclr = 1'b0;
  endtask

  task automatic preload(input int n);
    hold1 = 1'b1;
    for (int k = 1; k <= n; k++) writeWord(20'(k));
  endtask

  task automatic applyStimulus(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      dout_ready = vec[i].ready;
      hold1 = 1'b0;
      @(negedge clock);
      checkOutput($sformatf("vec%0d rdreq", i), 32'(fifo_rdreq1), 32'(vec[i].rdreq));
      checkOutput($sformatf("vec%0d valid", i), 32'(dout_valid1), 32'(vec[i].valid));
      checkOutput($sformatf("vec%0d busy", i), 32'(busy1), 32'(vec[i].busy));
      if (vec[i].valid) checkOutput($sformatf("vec%0d dout", i), 32'(dout1), 32'(vec[i].dout));
      @(posedge clock); #1;
    end
  endtask

  task automatic drainWait(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clock);
      k++;
    end
    #1;
    checkOutput(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic done3 = 1'b0;
  int   n;

  initial begin
    // Ready-high burst: rows 0..10; stalled then released: rows 11..25.
    vec[0]  = mkVec(1'b1, 1'b1, 1'b0, 20'h0, 1'b0);
    vec[1]  = mkVec(1'b1, 1'b1, 1'b0, 20'h0, 1'b1);
    vec[2]  = mkVec(1'b1, 1'b1, 1'b1, 20'h1, 1'b1);
    vec[3]  = mkVec(1'b1, 1'b1, 1'b1, 20'h2, 1'b1);
    vec[4]  = mkVec(1'b1, 1'b1, 1'b1, 20'h3, 1'b1);
    vec[5]  = mkVec(1'b1, 1'b1, 1'b1, 20'h4, 1'b1);
    vec[6]  = mkVec(1'b1, 1'b1, 1'b1, 20'h5, 1'b1);
    vec[7]  = mkVec(1'b1, 1'b1, 1'b1, 20'h6, 1'b1);
    vec[8]  = mkVec(1'b1, 1'b0, 1'b1, 20'h7, 1'b1);
    vec[9]  = mkVec(1'b1, 1'b0, 1'b1, 20'h8, 1'b1);
    vec[10] = mkVec(1'b1, 1'b0, 1'b0, 20'h0, 1'b0);
    vec[11] = mkVec(1'b0, 1'b1, 1'b0, 20'h0, 1'b0);
    vec[12] = mkVec(1'b0, 1'b1, 1'b0, 20'h0, 1'b1);
    vec[13] = mkVec(1'b0, 1'b1, 1'b1, 20'h1, 1'b1);
    vec[14] = mkVec(1'b0, 1'b0, 1'b1, 20'h1, 1'b1);
    vec[15] = mkVec(1'b0, 1'b0, 1'b1, 20'h1, 1'b1);
    vec[16] = mkVec(1'b0, 1'b0, 1'b1, 20'h1, 1'b1);
    vec[17] = mkVec(1'b1, 1'b0, 1'b1, 20'h1, 1'b1);
    vec[18] = mkVec(1'b1, 1'b1, 1'b1, 20'h2, 1'b1);
    vec[19] = mkVec(1'b1, 1'b1, 1'b1, 20'h3, 1'b1);
    vec[20] = mkVec(1'b1, 1'b1, 1'b1, 20'h4, 1'b1);
    vec[21] = mkVec(1'b1, 1'b1, 1'b1, 20'h5, 1'b1);
    vec[22] = mkVec(1'b1, 1'b1, 1'b1, 20'h6, 1'b1);
    vec[23] = mkVec(1'b1, 1'b0, 1'b1, 20'h7, 1'b1);
    vec[24] = mkVec(1'b1, 1'b0, 1'b1, 20'h8, 1'b1);
    vec[25] = mkVec(1'b1, 1'b0, 1'b0, 20'h0, 1'b0);

    $display("[TB] reset values");
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset dout", 32'(dout1), 32'd0);
    checkOutput("reset valid", 32'(dout_valid1), 32'd0);
    checkOutput("reset busy", 32'(busy1), 32'd0);
    checkOutput("reset rdreq", 32'(fifo_rdreq1), 32'd0);
    checkOutput("reset valid2", 32'(dout_valid2), 32'd0);
    aclr = 1'b0;

    $display("[TB] ready-high burst");
    preload(8);
    applyStimulus(0, 10);

    $display("[TB] stall then release");
    doReset();
    preload(8);
    applyStimulus(11, 25);

    $display("[TB] random ready, 1000 words");
    doReset();
    hold1 = 1'b0;
    done3 = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 2) == 0) begin
            @(posedge clock); #1;
          end
          writeWord(20'($urandom));
        end
        drainWait("random drain", 20000);
        done3 = 1'b1;
      end
      begin
        while (!done3) begin
          @(posedge clock); #1;
          dout_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clock); #1;
    dout_ready = 1'b1;

    $display("[TB] latency 3, depth 5 burst");
    for (int k = 0; k < 32; k++) begin
      wr_en2 = 1'b1;
      wr_data2 = 20'h10000 + 20'(k);
      @(posedge clock); #1;
    end
    wr_en2 = 1'b0;
    hold2 = 1'b0;
    dout_ready2 = 1'b1;
    @(negedge clock);
    checkOutput("lat3 first rdreq", 32'(fifo_rdreq2), 32'd1);
    n = 0;
    while (!dout_valid2 && n < 12) begin
      @(negedge clock);
      n++;
    end
    checkOutput("lat3 first beat delay", 32'(n), 32'd4);
    for (int k = 0; k < 32; k++) begin
      checkOutput($sformatf("lat3 beat%0d valid", k), 32'(dout_valid2), 32'd1);
      checkOutput($sformatf("lat3 beat%0d data", k), 32'(dout2), 32'(20'h10000 + 20'(k)));
      @(negedge clock);
    end
    checkOutput("lat3 end valid", 32'(dout_valid2), 32'd0);
    checkOutput("lat3 end busy", 32'(busy2), 32'd0);
    @(posedge clock); #1;

    $display("[TB] sclr with words in flight");
    doReset();
    preload(8);
    hold1 = 1'b0;
    dout_ready = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    sclr = 1'b1;
    @(posedge clock); #1;
    sclr = 1'b0;
    @(negedge clock);
    checkOutput("sclr valid", 32'(dout_valid1), 32'd0);
    checkOutput("sclr busy", 32'(busy1), 32'd0);
    @(negedge clock);
    checkOutput("sclr stale return", 32'(dout_valid1), 32'd0);
    @(posedge clock); #1;
    dout_ready = 1'b1;
    writeWord(20'hABCDE);
    n = 0;
    while (!dout_valid1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    checkOutput("sclr fresh valid", 32'(dout_valid1), 32'd1);
    checkOutput("sclr fresh data", 32'(dout1), 32'h000ABCDE);
    @(posedge clock); #1;

    $display("[TB] async aclr mid-burst");
    doReset();
    preload(8);
    hold1 = 1'b0;
    dout_ready = 1'b1;
    repeat (4) @(posedge clock);
    #3;
    aclr = 1'b1;
    #1;
    checkOutput("aclr dout", 32'(dout1), 32'd0);
    checkOutput("aclr valid", 32'(dout_valid1), 32'd0);
    checkOutput("aclr busy", 32'(busy1), 32'd0);
    checkOutput("aclr rdreq", 32'(fifo_rdreq1), 32'd0);
    @(posedge clock); #1;
    aclr = 1'b0;
    for (int k = 0; k < 4; k++) writeWord(20'h00100 + 20'(k));
    drainWait("aclr resume drain", 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scfifo_normal_rd_stream.md
# scfifo_normal_rd_stream

Read-side adapter for the single-clock normal-mode (non-show-ahead) M20K FIFOs. It issues `fifo_rdreq` against the FIFO's `empty` flag and absorbs the fixed FIFO read latency in a small credit-controlled skid buffer. It presents the data as a valid/ready stream with registered outputs. It sits between any `scfifo_s_*` normal-mode instance and a downstream consumer that may stall on any cycle.

## Interface
- `WIDTH`, 20: data width; must match the FIFO.
- `READ_LATENCY`, 1: cycles from `fifo_rdreq` high to the corresponding word valid on `fifo_q`; legal range 1..3.
- `SKID_DEPTH`, `READ_LATENCY`+2: total buffer entries, including the output register; must be ≥ `READ_LATENCY`+2 (elaboration `$error` otherwise).
- `clock`  in  1  sole clock; every register is on the rising edge.
- `aclr`  in  1  asynchronous, active-high reset; clears all state.
- `sclr`  in  1  synchronous clear, same effect as `aclr`; asserted together with the FIFO's `sclr`.
- `fifo_q`  in  `WIDTH`  FIFO read data.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rdreq`  out  1  FIFO read request.
- `dout`  out  `WIDTH`  stream data.
- `dout_valid`  out  1  stream valid.
- `dout_ready`  in  1  consumer ready.
- `busy`  out  1  high while any word is in flight or buffered.

## Operation
- `credits` counter, width clog2(`SKID_DEPTH`+1): number of words issued and not yet consumed. It counts both in-flight reads and buffered words.
- `fifo_rdreq = ~fifo_empty & (credits < SKID_DEPTH)`.
  - Depends only on registered state and `fifo_empty`.
  - No combinational path from `dout_ready` to `fifo_rdreq`.
- Pop: `dout_valid & dout_ready`.
- Credit update per cycle: `credits <= credits + fifo_rdreq - pop`; simultaneous issue and pop leave it unchanged.
- Return tracking: a `READ_LATENCY`-deep valid shift register takes `fifo_rdreq` at its input. Its output marks `fifo_q` as a returned word, and that word is written into the buffer in that cycle.
- Buffer:
  - Output register (`dout`/`dout_valid`) plus a register ring of `SKID_DEPTH`-1 entries.
  - A returned word goes straight to the output register if the output register is empty, or is being popped while the ring is empty.
  - Otherwise the returned word enters the ring.
  - On a pop, the ring head refills the output register.
- Ordering: strict FIFO order is preserved; no word is dropped or duplicated.
- Overflow cannot occur: credits bound ring occupancy. The bench asserts this.
- Underflow: `fifo_rdreq` is never asserted while `fifo_empty`=1.
- `busy = (credits != 0)`.
- `sclr`/`aclr`:
  - Clear credits, the valid shift register, both ring pointers, the output register and `dout_valid`.
  - Words in flight at clear time are discarded.
  - Hold has no meaning; the block re-issues from scratch once the clear is released.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `busy`=0, `fifo_rdreq`=0 (credits=0 but `fifo_empty`=1 from the FIFO's own reset).
- Latency: `fifo_rdreq` at cycle t gives `dout_valid` at t+`READ_LATENCY`+1 when the buffer is empty.
- Throughput: with `dout_ready` held at 1 and the FIFO non-empty, one word per cycle sustained. At the minimum `SKID_DEPTH`, credits settle at `READ_LATENCY`+1.
- Stall: with `dout_ready`=0, issue stops once credits=`SKID_DEPTH`. All `SKID_DEPTH` words are held without loss.
- Stream rule: while `dout_valid`=1 and `dout_ready`=0, `dout` holds stable.
- `fifo_empty` rising mid-burst: issue stops the same cycle; in-flight words still drain.

## Structure
- Package `scfifo_pkg`:
  - Read-latency range constants, shared by all `scfifo_s_*` normal-mode variants.
  - Credit-width function clog2(`SKID_DEPTH`+1).
- One sub-module, `scfifo_rd_skid_ring`: the register ring with head/tail pointers, push/pop, and count. The output-register logic stays in the top level.

## Test plan
Common configuration: `WIDTH`=20, `READ_LATENCY`=1, `SKID_DEPTH`=3.
1. Reset, then FIFO preloaded with 0x00001..0x00008, `dout_ready`=1:
   - first `dout_valid` two cycles after the first `fifo_rdreq`;
   - eight consecutive beats 0x00001..0x00008;
   - `busy` falls one cycle after the last pop.
2. Same preload, `dout_ready`=0:
   - `fifo_rdreq` high for exactly 3 cycles, then low;
   - `dout`=0x00001 stable.
   - Then raise `dout_ready`: 0x00001..0x00008 emerge in order with no gap after the first beat.
3. Random `dout_ready` (50%) over 1000 words written at a random rate:
   - scoreboard shows exact order;
   - credits never exceed 3;
   - no `fifo_rdreq` while `fifo_empty`.
4. `READ_LATENCY`=3, `SKID_DEPTH`=5, `dout_ready`=1, FIFO full of 32 words: 32 back-to-back beats, first beat 4 cycles after the first `fifo_rdreq`.
5. `sclr` asserted for one cycle with 2 words in flight and 1 buffered:
   - next cycle `dout_valid`=0, `busy`=0;
   - stale `fifo_q` returns are not output;
   - a fresh word written afterwards is output correctly.
6. `aclr` pulsed asynchronously mid-burst: all outputs go to reset values immediately; normal operation resumes after release.
